// File: rtl/fifo_sram_rf_2p.sv
// 1R1W register-file memory with per-word even parity and a zero-fill clear engine,
// used as the SRAM port responder of the iDMA read-path FIFO.
module fifo_sram_rf_2p #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_re,
    input  logic [ADDR_W-1:0] sram_raddr,
    output logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_we,
    input  logic [ADDR_W-1:0] sram_waddr,
    input  logic [DATA_W-1:0] sram_wdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              par_err,
    output logic [ADDR_W-1:0] par_err_addr
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam state_e           RST_STATE = CLR_ON_RST ? S_CLEAR : S_IDLE;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_clr_cnt;

    logic [DATA_W:0]   r_mem [DEPTH];
    logic              w_idle;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W:0]   w_mem_wword;

    logic              w_rd_en;
    logic              w_collide;
    logic [DATA_W:0]   w_rd_word;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rpar;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_err_addr;
    logic              w_par_err;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_start) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_cnt == LAST_CNT) w_state_nxt = S_IDLE;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
        end
    end

    assign w_idle      = (r_state == S_IDLE);
    assign w_mem_we    = rst_n && (w_idle ? sram_we : 1'b1);
    assign w_mem_waddr = w_idle ? sram_waddr : r_clr_cnt[ADDR_W-1:0];
    assign w_mem_wword = w_idle ? {^sram_wdata, sram_wdata} : '0;

    // NOTE: the storage array has no reset; zero-filling is the clear engine's job.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wword;
    end

    // Write-first on a same-address collision: forward the incoming word and its parity.
    assign w_rd_en   = w_idle && sram_re;
    assign w_collide = sram_we && (sram_waddr == sram_raddr);
    assign w_rd_word = w_collide ? {^sram_wdata, sram_wdata} : r_mem[sram_raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= '0;
            r_rpar     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_raddr    <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                {r_rpar, r_rdata} <= w_rd_word;
                r_raddr           <= sram_raddr;
            end
        end
    end

    // Check runs on the registered word, so the pulse lines up with the data it flags.
    assign w_par_err = r_rd_valid && (r_rpar != ^r_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_addr <= '0;
        end else if (w_par_err) begin
            r_err_addr <= r_raddr;
        end
    end

    assign sram_rdata   = r_rdata;
    assign par_err      = w_par_err;
    assign par_err_addr = w_par_err ? r_raddr : r_err_addr;
    assign clr_busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_fifo_sram_rf_2p.sv
// Self-checking bench for fifo_sram_rf_2p: directed scenarios, randomized traffic and a
// FIFO-style push/pop run, all checked against a behavioural memory model.
module tb_fifo_sram_rf_2p;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sram_re = 1'b0;
    logic [ADDR_W-1:0] sram_raddr = '0;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we = 1'b0;
    logic [ADDR_W-1:0] sram_waddr = '0;
    logic [DATA_W-1:0] sram_wdata = '0;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              par_err;
    logic [ADDR_W-1:0] par_err_addr;

    int n_checks = 0;
    int n_errors = 0;
    bit running  = 1'b1;

    fifo_sram_rf_2p #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLR_ON_RST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .par_err(par_err), .par_err_addr(par_err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word/parity arrays plus the number of clear cycles still owed.
    logic [DATA_W-1:0] m_data [DEPTH];
    bit                m_par  [DEPTH];
    int                m_left;
    logic [DATA_W-1:0] exp_rdata;
    bit                exp_pe;
    logic [ADDR_W-1:0] exp_err_addr;

    function automatic void reset_model();
        m_left       = DEPTH;
        exp_rdata    = '0;
        exp_pe       = 1'b0;
        exp_err_addr = '0;
    endfunction

    initial reset_model();
    always @(negedge rst_n) reset_model();

    always @(posedge clk) begin
        logic [DATA_W-1:0] d;
        bit                p;
        if (rst_n) begin
            exp_pe = 1'b0;
            if (m_left > 0) begin
                m_data[DEPTH - m_left] = '0;
                m_par[DEPTH - m_left]  = 1'b0;
                m_left--;
            end else begin
                if (sram_re) begin
                    if (sram_we && sram_waddr == sram_raddr) begin
                        d = sram_wdata;
                        p = ^sram_wdata;
                    end else begin
                        d = m_data[sram_raddr];
                        p = m_par[sram_raddr];
                    end
                    exp_rdata = d;
                    if (p != ^d) begin
                        exp_pe       = 1'b1;
                        exp_err_addr = sram_raddr;
                    end
                end
                if (sram_we) begin
                    m_data[sram_waddr] = sram_wdata;
                    m_par[sram_waddr]  = ^sram_wdata;
                end
                if (clr_start) m_left = DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            check("cmp_rdata", sram_rdata, exp_rdata);
            check("cmp_par_err", 64'(par_err), 64'(exp_pe));
            check("cmp_par_err_addr", 64'(par_err_addr), 64'(exp_err_addr));
            check("cmp_clr_busy", 64'(clr_busy), 64'(m_left > 0));
        end
    end

    task automatic drive(input bit re, input logic [ADDR_W-1:0] ra, input bit we,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, input bit cs);
        sram_re    = re;
        sram_raddr = ra;
        sram_we    = we;
        sram_waddr = wa;
        sram_wdata = wd;
        clr_start  = cs;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Counts busy cycles starting at the current negedge; optionally hammers traffic meanwhile.
    task automatic measure_sweep(input bit traffic, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!clr_busy) break;
            n++;
            if (traffic)
                drive(1'b1, ADDR_W'($urandom), 1'b1, 6'd9, {DATA_W{1'b1}}, n == 30);
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic read_check(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v, input string name);
        @(negedge clk);
        drive(1'b1, a, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        drive_idle();
        check(name, sram_rdata, v);
        check({name, "_perr"}, 64'(par_err), 64'd0);
    endtask

    initial begin
        int                n;
        logic [DATA_W-1:0] v;
        int                pushed, popped, cnt;
        logic [ADDR_W-1:0] wp, rp;
        bit                pend, do_push, do_pop;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", sram_rdata, 64'd0);
        check("rst_par_err", 64'(par_err), 64'd0);
        check("rst_par_err_addr", 64'(par_err_addr), 64'd0);
        check("rst_clr_busy", 64'(clr_busy), 64'd1);

        // Reset-release sweep lasts DEPTH cycles, then the array reads zero
        rst_n = 1'b1;
        measure_sweep(1'b0, n);
        check("rst_sweep_len", 64'(n), 64'd64);
        for (int a = 0; a < DEPTH; a++) read_check(ADDR_W'(a), '0, "post_clear_zero");

        // Write/read latency and hold
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 6'd5, 64'hDEAD_BEEF_0123_4567, 1'b0);
        read_check(6'd5, 64'hDEAD_BEEF_0123_4567, "wr_rd_latency");
        repeat (8) begin
            @(negedge clk);
            check("rdata_hold", sram_rdata, 64'hDEAD_BEEF_0123_4567);
        end

        // Same-address collision is write-first
        @(negedge clk);
        drive(1'b1, 6'd7, 1'b1, 6'd7, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        @(negedge clk);
        drive_idle();
        check("collision_data", sram_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
        check("collision_perr", 64'(par_err), 64'd0);

        // Parity injection at address 3
        v = 64'h0F0F_1234_5678_9ABD;
        @(negedge clk);
        dut.r_mem[3] <= {~(^v), v};
        m_data[3] = v;
        m_par[3]  = ~(^v);
        drive(1'b1, 6'd3, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        drive(1'b1, 6'd5, 1'b0, '0, '0, 1'b0);
        check("inj_perr", 64'(par_err), 64'd1);
        check("inj_perr_addr", 64'(par_err_addr), 64'd3);
        check("inj_data", sram_rdata, v);
        @(negedge clk);
        drive_idle();
        check("inj_clean_perr", 64'(par_err), 64'd0);
        check("inj_clean_addr", 64'(par_err_addr), 64'd3);
        check("inj_clean_data", sram_rdata, 64'hDEAD_BEEF_0123_4567);

        // Clear during traffic, with a second clr_start mid-sweep
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 6'd9, 64'h1234_0000_5678_0000, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        drive_idle();
        measure_sweep(1'b1, n);
        check("traffic_sweep_len", 64'(n), 64'd64);
        read_check(6'd9, '0, "addr9_cleared");

        // Randomized traffic; narrow address range half the time to provoke collisions
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c % 2 == 0)
                drive(1'($urandom), ADDR_W'($urandom_range(0, 3)), 1'($urandom),
                      ADDR_W'($urandom_range(0, 3)), {$urandom, $urandom}, ($urandom % 400) == 0);
            else
                drive(1'($urandom), ADDR_W'($urandom), 1'($urandom),
                      ADDR_W'($urandom), {$urandom, $urandom}, ($urandom % 400) == 0);
        end
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 100 && clr_busy; i++) @(negedge clk);

        // Asynchronous reset in the middle of a sweep restarts it from address 0
        drive(1'b0, '0, 1'b1, 6'd12, 64'h5555_6666_7777_8888, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        drive_idle();
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(clr_busy), 64'd1);
        check("midrst_rdata", sram_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        measure_sweep(1'b0, n);
        check("midrst_sweep_len", 64'(n), 64'd64);
        read_check(6'd12, '0, "midrst_addr12");

        // FIFO pairing: 200 incrementing words through a 64-entry ring with random stalls
        pushed = 0; popped = 0; cnt = 0; wp = '0; rp = '0; pend = 1'b0;
        for (int c = 0; c < 5000 && popped < 200; c++) begin
            @(negedge clk);
            if (pend) begin
                check("fifo_pop_data", sram_rdata, 64'(popped));
                check("fifo_pop_perr", 64'(par_err), 64'd0);
                popped++;
            end
            do_push = (pushed < 200) && (cnt < DEPTH) && ($urandom % 4 != 0);
            do_pop  = (cnt > 0) && !do_push && ($urandom % 3 != 0);
            drive(do_pop, rp, do_push, wp, 64'(pushed), 1'b0);
            if (do_push) begin wp++; pushed++; cnt++; end
            if (do_pop)  begin rp++; cnt--; end
            pend = do_pop;
        end
        @(negedge clk);
        drive_idle();
        check("fifo_pop_count", 64'(popped), 64'd200);

        repeat (2) @(negedge clk);
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
